cpld_uart_ctrl: RTL

CPU-side initiator for the CPLD-hosted UART on the shared BaseRAM data lines. It sits between the CPU's memory-mapped I/O path and the thinpad pins, and exposes a 16550-style data and status pair to software. It sequences `uart_rdn`/`uart_wrn`, tracks `uart_dataready`/`uart_tbre`/`uart_tsre`, and arbitrates with the SRAM controller for ownership of `base_ram_data[7:0]`.

---
 rtl/uart_pkg.sv | 33 +++
 rtl/uart_rx_fifo.sv | 57 +++++
 rtl/cpld_uart_ctrl.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the CPLD UART initiator: register offsets,
// line-status bit positions, the sequencer state enum and a helper that
// assembles the status byte.
package uart_pkg;

   localparam logic [2:0] UART_DATA_OFS = 3'd0;
   localparam logic [2:0] UART_STAT_OFS = 3'd5;

   localparam int UART_LSR_DR   = 0;
   localparam int UART_LSR_THRE = 5;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_ACQ,
      ST_WR_STB,
      ST_WR_HOLD,
      ST_WR_TBRE,
      ST_WR_TSRE,
      ST_RD_STB,
      ST_RD_SAMP,
      ST_RESP
   } uart_state_e;

   // Status byte as seen by software: only DR and THRE are populated.
   function automatic logic [7:0] lsr_byte(input logic dr, input logic thre);
      logic [7:0] s;
      s                = 8'h00;
      s[UART_LSR_DR]   = dr;
      s[UART_LSR_THRE] = thre;
      return s;
   endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Small synchronous RX byte buffer for the CPLD UART initiator.
// Only built when UART_RX_FIFO_EN is defined. Full/empty derive from an
// occupancy count; pointers wrap naturally because DEPTH is a power of 2.
`ifdef UART_RX_FIFO_EN
module uart_rx_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             empty,
   output logic             full
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             push_ok;
   logic             pop_ok;

   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign empty   = (count == '0);
   assign full    = (count == (AW+1)'(DEPTH));
   assign rdata   = mem[rd_ptr];

   // Storage array, written on accepted pushes only.
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= wdata;
   end

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
         case ({push_ok, pop_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule
`endif

// File: rtl/cpld_uart_ctrl.sv
// CPU-side initiator for the CPLD UART sharing base_ram_data[7:0].
// Sequences uart_rdn/uart_wrn, tracks the CPLD status lines and requests
// ownership of the shared byte lane from the SRAM controller.
// Optional feature macro: UART_RX_FIFO_EN (autonomous RX drain into a
// small buffer); without it, data reads strobe the CPLD directly.
module cpld_uart_ctrl
   import uart_pkg::*;
#(
   parameter int PULSE_CYC   = 4,
   parameter int SYNC_STAGES = 2,
   parameter int RX_DEPTH    = 4
) (
   input  logic       clk_50M,
   input  logic       reset_btn,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic       req_we,
   input  logic [2:0] req_addr,
   input  logic [7:0] req_wdata,
   output logic       resp_valid,
   output logic [7:0] resp_rdata,
   output logic       bus_req,
   input  logic       bus_gnt,
   output logic [7:0] data_o,
   output logic       data_oe,
   input  logic [7:0] data_i,
   output logic       uart_rdn,
   output logic       uart_wrn,
   input  logic       uart_dataready,
   input  logic       uart_tbre,
   input  logic       uart_tsre
);

   localparam int CNT_W = (PULSE_CYC > 1) ? $clog2(PULSE_CYC) : 1;

   if (PULSE_CYC < 1) begin : g_bad_pulse
      $error("PULSE_CYC must be at least 1");
   end
   if (SYNC_STAGES < 1) begin : g_bad_sync
      $error("SYNC_STAGES must be at least 1");
   end
   if ((RX_DEPTH < 2) || ((RX_DEPTH & (RX_DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("RX_DEPTH must be a power of two, at least 2");
   end

   uart_state_e      state;
   logic [CNT_W-1:0] cnt;
   logic             is_wr;
   logic [7:0]       wbyte;
   logic [2:0]       sync_p [SYNC_STAGES];
   logic             dr_s;
   logic             tbre_s;
   logic             tsre_s;
   logic             thre;
   logic             accept;

   assign dr_s   = sync_p[SYNC_STAGES-1][0];
   assign tbre_s = sync_p[SYNC_STAGES-1][1];
   assign tsre_s = sync_p[SYNC_STAGES-1][2];
   assign accept = req_valid && req_ready && (state == ST_IDLE);
   assign thre   = tsre_s && !(state inside {ST_WR_STB, ST_WR_HOLD, ST_WR_TBRE, ST_WR_TSRE}
                               || (state == ST_ACQ && is_wr));

`ifdef UART_RX_FIFO_EN
   logic [7:0] fifo_rdata;
   logic       fifo_empty;
   logic       fifo_full;
   logic       fifo_push;
   logic       fifo_pop;

   // Every read strobe in this build is an autonomous drain.
   assign fifo_push = (state == ST_RD_STB) && (cnt == '0);
   assign fifo_pop  = accept && !req_we && (req_addr == UART_DATA_OFS);

   uart_rx_fifo #(
      .DEPTH (RX_DEPTH),
      .WIDTH (8)
   ) u_rx_fifo (
      .clk   (clk_50M),
      .rst   (reset_btn),
      .push  (fifo_push),
      .wdata (data_i),
      .pop   (fifo_pop),
      .rdata (fifo_rdata),
      .empty (fifo_empty),
      .full  (fifo_full)
   );
`endif

   // Bring the asynchronous CPLD status lines into the clock domain.
   always_ff @(posedge clk_50M or posedge reset_btn) begin
      if (reset_btn) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_p[i] <= 3'b000;
      end else begin
         sync_p[0] <= {uart_tsre, uart_tbre, uart_dataready};
         for (int i = 1; i < SYNC_STAGES; i++) sync_p[i] <= sync_p[i-1];
      end
   end

   // Latch the transmit byte when a request is accepted.
   always_ff @(posedge clk_50M) begin
      if (accept) wbyte <= req_wdata;
   end

   // Access sequencer with registered bus, strobe and response outputs.
   always_ff @(posedge clk_50M or posedge reset_btn) begin
      if (reset_btn) begin
         state      <= ST_IDLE;
         cnt        <= '0;
         is_wr      <= 1'b0;
         req_ready  <= 1'b0;
         resp_valid <= 1'b0;
         resp_rdata <= 8'h00;
         bus_req    <= 1'b0;
         data_o     <= 8'h00;
         data_oe    <= 1'b0;
         uart_rdn   <= 1'b1;
         uart_wrn   <= 1'b1;
      end else begin
         resp_valid <= 1'b0;
         case (state)
            ST_IDLE: begin
               req_ready <= 1'b1;
               if (accept) begin
                  req_ready <= 1'b0;
                  if (req_we && req_addr == UART_DATA_OFS) begin
                     is_wr   <= 1'b1;
                     bus_req <= 1'b1;
                     state   <= ST_ACQ;
                  end else if (!req_we && req_addr == UART_DATA_OFS) begin
`ifdef UART_RX_FIFO_EN
                     resp_rdata <= fifo_empty ? 8'h00 : fifo_rdata;
                     resp_valid <= 1'b1;
                     state      <= ST_RESP;
`else
                     if (dr_s) begin
                        is_wr   <= 1'b0;
                        bus_req <= 1'b1;
                        state   <= ST_ACQ;
                     end else begin
                        resp_rdata <= 8'h00;
                        resp_valid <= 1'b1;
                        state      <= ST_RESP;
                     end
`endif
                  end else if (!req_we && req_addr == UART_STAT_OFS) begin
`ifdef UART_RX_FIFO_EN
                     resp_rdata <= lsr_byte(!fifo_empty, thre);
`else
                     resp_rdata <= lsr_byte(dr_s, thre);
`endif
                     resp_valid <= 1'b1;
                     state      <= ST_RESP;
                  end else begin
                     // Unmapped offsets and writes to status: no bus traffic.
                     resp_rdata <= 8'h00;
                     resp_valid <= 1'b1;
                     state      <= ST_RESP;
                  end
               end
`ifdef UART_RX_FIFO_EN
               else if (!req_valid && dr_s && !fifo_full) begin
                  req_ready <= 1'b0;
                  is_wr     <= 1'b0;
                  bus_req   <= 1'b1;
                  state     <= ST_ACQ;
               end
`endif
            end
            ST_ACQ: begin
               if (bus_gnt) begin
                  cnt <= CNT_W'(PULSE_CYC - 1);
                  if (is_wr) begin
                     data_o   <= wbyte;
                     data_oe  <= 1'b1;
                     uart_wrn <= 1'b0;
                     state    <= ST_WR_STB;
                  end else begin
                     uart_rdn <= 1'b0;
                     state    <= ST_RD_STB;
                  end
               end
            end
            ST_WR_STB: begin
               if (cnt == '0) begin
                  uart_wrn <= 1'b1;
                  state    <= ST_WR_HOLD;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            ST_WR_HOLD: begin
               data_oe <= 1'b0;
               data_o  <= 8'h00;
               bus_req <= 1'b0;
               state   <= ST_WR_TBRE;
            end
            ST_WR_TBRE: begin
               if (tbre_s) state <= ST_WR_TSRE;
            end
            ST_WR_TSRE: begin
               if (tsre_s) begin
                  resp_rdata <= 8'h00;
                  resp_valid <= 1'b1;
                  state      <= ST_RESP;
               end
            end
            ST_RD_STB: begin
               if (cnt == '0) begin
                  // Last low cycle: the CPLD byte is stable on data_i here.
                  uart_rdn <= 1'b1;
                  bus_req  <= 1'b0;
`ifndef UART_RX_FIFO_EN
                  resp_rdata <= data_i;
`endif
                  state <= ST_RD_SAMP;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            ST_RD_SAMP: begin
`ifdef UART_RX_FIFO_EN
               req_ready <= 1'b1;
               state     <= ST_IDLE;
`else
               resp_valid <= 1'b1;
               state      <= ST_RESP;
`endif
            end
            ST_RESP: begin
               req_ready <= 1'b1;
               state     <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
